inst_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate generator and control decoder.
- Holds the PC and issues in-order word fetches to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered instructions and discarding in-flight responses.

---
 rtl/inst_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage feeding the immediate generator and
// control decoder. Issues in-order word fetches over a req/gnt + rvalid memory
// interface, buffers returned words with their PC, and presents them to decode
// over valid/ready. Redirects flush the buffer and drop all in-flight responses.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        protocol_err
);

  // One extra bit so outstanding + fifo_count (up to 2*FIFO_DEPTH) never wraps.
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int QPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [QPTR_W-1:0] QPTR_LAST = QPTR_W'(MAX_OUTSTANDING - 1);

  // Fetch state
  logic [31:0]       r_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_protocol_err;

  // PC queue: address of every granted, not yet returned request
  logic [31:0]       r_pcq [MAX_OUTSTANDING];
  logic [QPTR_W-1:0] r_pcq_wr;
  logic [QPTR_W-1:0] r_pcq_rd;

  // Instruction buffer
  logic [31:0]       r_fifo_inst [FIFO_DEPTH];
  logic [31:0]       r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_req;
  logic              w_grant;
  logic              w_resp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [31:0]       w_redirect_target;
  logic [CNT_W-1:0]  w_inflight_after_resp;

  function automatic logic [QPTR_W-1:0] qptr_next(input logic [QPTR_W-1:0] p);
    return (p == QPTR_LAST) ? '0 : p + QPTR_W'(1);
  endfunction

  // Credit: a new request must fit both the outstanding limit and the buffer,
  // counting every in-flight word as if it will be kept.
  assign w_req = !rst && !redirect_valid &&
                 (r_outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                 ((r_outstanding + r_count) < CNT_W'(FIFO_DEPTH));

  assign w_grant  = w_req && imem_gnt;
  // A response with nothing outstanding is a stray; it is flagged and ignored.
  assign w_resp   = imem_rvalid && (r_outstanding != '0);
  assign w_drop   = w_resp && (r_drop_cnt != '0);
  assign w_push   = w_resp && !w_drop && !redirect_valid;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && inst_ready;

  assign w_redirect_target     = redirect_pc & 32'hFFFF_FFFC;
  assign w_inflight_after_resp = r_outstanding - CNT_W'(w_resp);

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign inst_valid   = w_valid;
  // Gated so the unreset buffer storage never reaches decode while empty.
  assign inst_out     = w_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign inst_pc      = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
  assign protocol_err = r_protocol_err;

  // PC advance on grant, reload on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC & 32'hFFFF_FFFC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_grant) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Outstanding-request count and the number of in-flight words to discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      case ({w_grant, w_resp})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      // No grant happens during a redirect, so everything still in flight
      // afterwards is exactly the outstanding count minus this cycle's response.
      if (redirect_valid) begin
        r_drop_cnt <= w_inflight_after_resp;
      end else if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  // PC queue pointers: push on grant, pop on every accepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcq_wr <= '0;
      r_pcq_rd <= '0;
    end else begin
      if (w_grant) r_pcq_wr <= qptr_next(r_pcq_wr);
      if (w_resp)  r_pcq_rd <= qptr_next(r_pcq_rd);
    end
  end

  // PC queue storage.
  always_ff @(posedge clk) begin
    if (w_grant) r_pcq[r_pcq_wr] <= r_pc;
  end

  // Instruction buffer pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Instruction buffer storage: word plus the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
    end
  end

  // Sticky stray-response flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if (imem_rvalid && (r_outstanding == '0)) begin
      r_protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a randomized memory and decode environment drives
// the main instance against a queue-based reference model; a second instance
// with RESET_PC near the top of memory runs a 1-cycle memory continuously.
module tb_inst_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam int          MAXO    = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        protocol_err;

  logic        w_req, w_rvalid, w_valid, w_perr;
  logic [31:0] w_addr, w_rdata, w_out, w_pc;

  inst_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .protocol_err(protocol_err)
  );

  inst_fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(1'b1),
    .inst_out(w_out), .inst_pc(w_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .protocol_err(w_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct { logic [31:0] pc; bit keep; } fl_t;
  typedef struct { logic [31:0] w; logic [31:0] pc; } oq_t;
  typedef struct { logic [31:0] a; int due; } mq_t;
  fl_t         infl[$];   // requests granted and not yet returned
  oq_t         outq[$];   // words decode should see, in order
  mq_t         memq[$];   // memory-side pending responses
  logic [31:0] m_pc;
  bit          m_perr;
  int          cyc;

  // Environment knobs
  int          gnt_pct, ready_pct, resp_pct, lat_min, lat_max;
  bit          hold_resp, redir_now, stray_now;
  logic [31:0] redir_addr;

  // Second-instance tracking
  bit          w_gnt_d;
  logic [31:0] w_addr_d;
  logic [31:0] w_exp;
  int          w_cyc;

  int vectors;
  int miscompares;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00A00113;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_rvalid = 1'b0; w_rdata = 32'h0;
    #1;
    chk("rst imem_req", imem_req, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst_out", inst_out, 0);
    chk("rst inst_pc", inst_pc, 0);
    chk("rst protocol_err", protocol_err, 0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst w_req", w_req, 0);
    chk("rst w_valid", w_valid, 0);
    chk("rst w_perr", w_perr, 0);
    infl.delete(); outq.delete(); memq.delete();
    m_pc = 32'h0; m_perr = 1'b0; cyc = 0;
    w_gnt_d = 1'b0; w_addr_d = 32'h0; w_exp = WRAP_PC; w_cyc = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, update model.
  task automatic cycle();
    bit   exp_req;
    fl_t  f;
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    inst_ready     = ($urandom_range(99) < ready_pct);
    redirect_valid = redir_now;
    redirect_pc    = redir_addr;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (stray_now) begin
      imem_rvalid = 1'b1;
    end else if (!hold_resp && memq.size() > 0 && memq[0].due <= cyc &&
                 $urandom_range(99) < resp_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].a);
      void'(memq.pop_front());
    end
    w_rvalid = w_gnt_d;
    w_rdata  = mem_word(w_addr_d);
    #1;
    exp_req = !redirect_valid && (infl.size() < MAXO) &&
              (infl.size() + outq.size() < DEPTH);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, outq.size() != 0);
    if (outq.size() != 0) begin
      chk("inst_pc", inst_pc, outq[0].pc);
      chk("inst_out", inst_out, outq[0].w);
    end
    chk("protocol_err", protocol_err, m_perr);

    // Second instance: 1-cycle memory, decode always ready.
    chk("w_req", w_req, 1);
    chk("w_addr", w_addr, WRAP_PC + 32'(4 * w_cyc));
    chk("w_valid", w_valid, w_cyc >= 2);
    if (w_valid) begin
      chk("w_pc", w_pc, w_exp);
      chk("w_out", w_out, mem_word(w_exp));
      w_exp = w_exp + 32'd4;
    end
    w_gnt_d  = w_req;
    w_addr_d = w_addr;
    w_cyc++;

    // Model update
    if (outq.size() != 0 && inst_ready) void'(outq.pop_front());
    if (imem_rvalid) begin
      if (infl.size() == 0) begin
        m_perr = 1'b1;
      end else begin
        f = infl.pop_front();
        if (f.keep && !redirect_valid) outq.push_back('{mem_word(f.pc), f.pc});
      end
    end
    if (imem_req && imem_gnt)
      memq.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    if (exp_req && imem_gnt) begin
      infl.push_back('{m_pc, 1'b1});
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      foreach (infl[i]) infl[i].keep = 1'b0;
      outq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0;
    gnt_pct = 100; ready_pct = 100; resp_pct = 100; lat_min = 1; lat_max = 1;
    hold_resp = 1'b0; redir_now = 1'b0; stray_now = 1'b0; redir_addr = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_rvalid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    do_reset();

    // Streaming with a 1-cycle memory: first word visible two cycles after reset.
    repeat (8) cycle();

    // Decode stalls: buffer fills to depth, requests stop, then drains in order.
    ready_pct = 0;
    repeat (10) cycle();
    ready_pct = 100;
    repeat (10) cycle();

    // Two requests in flight, redirect before either returns.
    gnt_pct = 0;
    repeat (6) cycle();
    hold_resp = 1'b1; gnt_pct = 100;
    repeat (2) cycle();
    redir_now = 1'b1; redir_addr = 32'h0000_0104;
    cycle();
    redir_now = 1'b0; hold_resp = 1'b0;
    repeat (8) cycle();

    // Back-to-back redirects while drops are pending.
    gnt_pct = 0;
    repeat (6) cycle();
    hold_resp = 1'b1; gnt_pct = 100;
    repeat (2) cycle();
    redir_now = 1'b1; redir_addr = 32'h0000_0200;
    cycle();
    redir_addr = 32'h0000_0300;
    cycle();
    redir_now = 1'b0; hold_resp = 1'b0;
    repeat (10) cycle();

    // Random traffic: grants, latencies, decode stalls and redirects.
    gnt_pct = 70; ready_pct = 60; resp_pct = 75; lat_min = 1; lat_max = 4;
    for (int n = 0; n < 3000; n++) begin
      redir_now  = ($urandom_range(19) == 0);
      redir_addr = $urandom;
      cycle();
    end
    redir_now = 1'b0;

    // Stray response with nothing outstanding.
    gnt_pct = 0; ready_pct = 0; resp_pct = 100;
    for (int n = 0; n < 50 && (infl.size() != 0 || memq.size() != 0); n++) cycle();
    chk("drain outstanding", 32'(infl.size()), 32'h0);
    stray_now = 1'b1;
    cycle();
    stray_now = 1'b0;
    repeat (3) cycle();

    // Reset mid-stream clears everything, including the sticky error.
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 2;
    repeat (10) cycle();
    do_reset();
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
